// File: rtl/alu_result_buffer.sv
// In-order result FIFO between the ALU and the CDB arbiter.
// It holds completed results until the CDB grants them.
module alu_result_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int PHYS_W     = 6,
  parameter int ROB_W      = 5,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_result,
  input  logic                     in_zero,
  input  logic [PHYS_W-1:0]        in_prd,
  input  logic [ROB_W-1:0]         in_rob_idx,
  output logic                     cdb_valid,
  input  logic                     cdb_ready,
  output logic [DATA_WIDTH-1:0]    cdb_result,
  output logic                     cdb_zero,
  output logic [PHYS_W-1:0]        cdb_prd,
  output logic [ROB_W-1:0]         cdb_rob_idx,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic                  zero;
    logic [PHYS_W-1:0]     prd;
    logic [ROB_W-1:0]      rob_idx;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head_entry;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic               push;
  logic               pop;

  // in_ready depends on count alone, so a full buffer never accepts even while popping
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign cdb_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = cdb_valid && cdb_ready;

  always_comb begin
    head_entry = '0;
    if (cdb_valid) begin
      head_entry = mem[head];
    end
  end

  assign cdb_result  = head_entry.result;
  assign cdb_zero    = head_entry.zero;
  assign cdb_prd     = head_entry.prd;
  assign cdb_rob_idx = head_entry.rob_idx;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      mem[tail] <= '{result: in_result, zero: in_zero, prd: in_prd, rob_idx: in_rob_idx};
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    (count <= CNT_W'(DEPTH)) && (tail == PTR_W'(head + count[PTR_W-1:0])));

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Sits between the ALU execution unit and the common data bus (CDB); it is the consumer end of the ALU result path.
- Captures each completed ALU result with its physical destination tag, ROB index and zero flag into a small in-order FIFO.
- Presents the oldest entry to the CDB arbiter under a valid/ready handshake.
- Decouples ALU completion from CDB grant so the ALU never stalls on a lost arbitration until the buffer is full.

Parameters:
- DATA_WIDTH, 32, result width.
- PHYS_W, 6, physical register tag width.
- ROB_W, 5, ROB index width.
- DEPTH, 4, number of entries; power of two, >= 2.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- flush  input  1  pipeline flush (mispredict/exception); discards all entries.
- in_valid  input  1  ALU result valid this cycle.
- in_ready  output  1  buffer can accept a result.
- in_result  input  DATA_WIDTH  ALU result.
- in_zero  input  1  ALU zero flag.
- in_prd  input  PHYS_W  physical destination tag.
- in_rob_idx  input  ROB_W  ROB index.
- cdb_valid  output  1  head entry available.
- cdb_ready  input  1  CDB grant; head is consumed when cdb_valid && cdb_ready.
- cdb_result  output  DATA_WIDTH  head result.
- cdb_zero  output  1  head zero flag.
- cdb_prd  output  PHYS_W  head tag.
- cdb_rob_idx  output  ROB_W  head ROB index.
- count  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Storage: circular FIFO with head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH; count register 0..DEPTH.
- Push: in_valid && in_ready at a clock edge writes the entry at tail; tail advances by 1.
- Pop: cdb_valid && cdb_ready at a clock edge; head advances by 1.
- in_ready = (count < DEPTH). It is combinational from count only, never from cdb_ready. A full buffer therefore refuses a push even if a pop occurs in the same cycle.
- cdb_valid = (count != 0). cdb_* data fields show the head entry when valid and are driven to 0 when empty.
- Latency: an entry pushed at edge N is visible on cdb_* after edge N; at least 1 cycle, no same-cycle bypass.
- Simultaneous push and pop (0 < count < DEPTH): both take effect and count is unchanged.
- Empty plus push: no pop possible that cycle; count becomes 1.
- Ordering: strict FIFO; results leave in ALU completion order.
- Flush: synchronous. At the edge, head = tail = count = 0. A push or pop presented in the same cycle is discarded. The cycle after flush shows cdb_valid = 0 and in_ready = 1.
- Reset has priority over flush and has identical effect. Reset values: cdb_valid = 0, in_ready = 1, count = 0, all cdb_* data = 0. Storage contents need not be cleared.
- in_valid while in_ready = 0: input ignored and not retained. The ALU side must hold the value; this is the sender's responsibility.
- cdb_ready while cdb_valid = 0: no effect.
- Assertions: count never exceeds DEPTH; pointers are consistent with count.

Test Plan:
1. Reset, then push {result 0x0000_0005, zero 0, prd 3, rob 7} with cdb_ready = 1. Required: cdb_valid rises the next cycle with those fields; popped that cycle; count returns to 0.
2. cdb_ready = 0; push 4 results 0x11, 0x22, 0x33, 0x44. Required: count = 4, in_ready = 0. A 5th push of 0x55 is ignored. Then cdb_ready = 1: outputs 0x11, 0x22, 0x33, 0x44 on consecutive cycles, never 0x55.
3. Steady stream with push and pop every cycle for 10 cycles at count = 2. Required: count stays 2; pointers wrap twice past DEPTH; order is preserved.
4. Count = 3, then assert flush together with in_valid (0xAA) and cdb_ready. Required: next cycle count = 0, cdb_valid = 0, in_ready = 1; 0xAA is never emitted; the head is not counted as consumed.
5. rst asserted mid-stream at count = 2. Required: next cycle all outputs at reset values; a subsequent push of 0x77 emerges as the first output.
6. Result 0x0 with in_zero = 1, prd 0x3F, rob 0x1F (maximum widths). Required: cdb_zero = 1, cdb_prd = 0x3F, cdb_rob_idx = 0x1F, with no field truncation.
